// File: rtl/doubled_syndrome_core_if.sv
// Bus bundle for doubled_syndrome_core: command/result handshake, syndrome read port,
// and the P / evaluation memory read ports. The core uses the slave modport.
interface doubled_syndrome_core_if #(
   parameter int unsigned M        = 12,
   parameter int unsigned T        = 64,
   parameter int unsigned MemWidth = 32
) ();
   localparam int unsigned AddrW = $clog2(2 * T);
   localparam int unsigned LaneW = $clog2(2 * MemWidth);

   logic [1:0]              operation;
   logic                    start;
   logic [M*T-1:0]          cipher;
   logic                    done;
   logic                    synd_rd_en_in;
   logic [AddrW-1:0]        synd_rd_addr_in;
   logic [M-1:0]            synd_A_dout_out;
   logic                    P_rd_en;
   logic [M-1:0]            P_rd_addr;
   logic [M-1:0]            P_dout;
   logic                    eva_rd_en;
   logic [M-LaneW-1:0]      eva_rd_addr;
   logic [2*M*MemWidth-1:0] eva_dout;

   modport master (
      output operation, start, cipher, synd_rd_en_in, synd_rd_addr_in, P_dout, eva_dout,
      input  done, synd_A_dout_out, P_rd_en, P_rd_addr, eva_rd_en, eva_rd_addr
   );

   modport slave (
      input  operation, start, cipher, synd_rd_en_in, synd_rd_addr_in, P_dout, eva_dout,
      output done, synd_A_dout_out, P_rd_en, P_rd_addr, eva_rd_en, eva_rd_addr
   );
endinterface

// File: rtl/doubled_syndrome_core.sv
// Doubled Goppa syndrome S_j = sum c_i * alpha_i^j / g(alpha_i)^2 over GF(2^M), j < 2T,
// accumulated into an internal 2T x M RAM that is readable while idle.
module doubled_syndrome_core #(
   parameter int unsigned M        = 12,
   parameter int unsigned T        = 64,
   parameter int unsigned N        = 3488,
   parameter int unsigned MemWidth = 32,
   parameter logic [M:0]  Poly     = 13'h1009
) (
   input logic                    clk,
   input logic                    rst,
   doubled_syndrome_core_if.slave bus
);
   localparam int unsigned AddrW = $clog2(2 * T);
   localparam int unsigned LaneW = $clog2(2 * MemWidth);
   localparam int unsigned IdxW  = $clog2(M * T);
   localparam int unsigned BitW  = $clog2(M);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(M * T - 1);
   localparam logic [AddrW-1:0] LastJ   = AddrW'(2 * T - 1);
   localparam logic [M-1:0]     InvExp  = M'((1 << M) - 3);
   // A mis-parameterised instance never leaves idle.
   localparam bit CfgOk = (M * T <= N) && (N <= (1 << M));

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StClear    = 3'd1;
   localparam logic [2:0] StScan     = 3'd2;
   localparam logic [2:0] StFetchP   = 3'd3;
   localparam logic [2:0] StFetchEva = 3'd4;
   localparam logic [2:0] StInv      = 3'd5;
   localparam logic [2:0] StAccum    = 3'd6;
   localparam logic [2:0] StDone     = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [AddrW-1:0] j_q, j_d;
   logic [M-1:0]     alpha_q, alpha_d, e_q, e_d, acc_q, acc_d, dout_q, dout_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic             mul_ph_q, mul_ph_d, load_q, load_d;

   logic [M-1:0] synd_mem [2*T];
   logic         ram_we;
   logic [M-1:0] ram_wdata, mul_b, mul_out, lane;

   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] r;
      r = '0;
      for (int k = M - 1; k >= 0; k--) begin
         r = {r[M-2:0], 1'b0} ^ (r[M-1] ? Poly[M-1:0] : '0);
         if (b[k]) r = r ^ a;
      end
      return r;
   endfunction

   // One multiplier: squares/multiplies by e during inversion, steps alpha^j during accumulate.
   always_comb begin
      mul_b = acc_q;
      if (state_q == StInv && mul_ph_q) mul_b = e_q;
      else if (state_q == StAccum)      mul_b = alpha_q;
   end
   assign mul_out = gf_mul(acc_q, mul_b);
   assign lane    = bus.eva_dout[M*alpha_q[LaneW-1:0] +: M];

   assign bus.done            = (state_q == StDone);
   assign bus.P_rd_en         = (state_q == StFetchP);
   assign bus.P_rd_addr       = bus.P_rd_en ? M'(idx_q) : '0;
   assign bus.eva_rd_en       = (state_q == StFetchEva);
   assign bus.eva_rd_addr     = bus.eva_rd_en ? bus.P_dout[M-1:LaneW] : '0;
   assign bus.synd_A_dout_out = dout_q;

   always_comb begin
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (state_q == StClear) begin
         ram_we = 1'b1;
      end else if (state_q == StAccum) begin
         ram_we    = 1'b1;
         ram_wdata = synd_mem[j_q] ^ acc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) synd_mem[j_q] <= ram_wdata;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      j_d      = j_q;
      alpha_d  = alpha_q;
      e_d      = e_q;
      acc_d    = acc_q;
      bit_d    = bit_q;
      mul_ph_d = mul_ph_q;
      load_d   = load_q;
      dout_d   = dout_q;
      case (state_q)
         StIdle: begin
            if (bus.synd_rd_en_in) dout_d = synd_mem[bus.synd_rd_addr_in];
            if (bus.start && bus.operation == 2'b01 && CfgOk) begin
               state_d = StClear;
               idx_d   = '0;
               j_d     = '0;
            end
         end
         StClear: begin
            j_d = j_q + 1'b1;
            if (j_q == LastJ) state_d = StScan;
         end
         StScan: begin
            if (bus.cipher[idx_q])    state_d = StFetchP;
            else if (idx_q == LastIdx) state_d = StDone;
            else                       idx_d   = idx_q + 1'b1;
         end
         StFetchP: state_d = StFetchEva;
         StFetchEva: begin
            alpha_d = bus.P_dout;
            load_d  = 1'b1;
            state_d = StInv;
         end
         StInv: begin
            // MSB-first square-and-multiply of e^(2^M-3) = e^-2; e = 0 yields 0.
            if (load_q) begin
               e_d      = lane;
               acc_d    = M'(1);
               bit_d    = BitW'(M - 1);
               mul_ph_d = 1'b0;
               load_d   = 1'b0;
            end else begin
               acc_d = mul_out;
               if (!mul_ph_q && InvExp[bit_q]) begin
                  mul_ph_d = 1'b1;
               end else begin
                  mul_ph_d = 1'b0;
                  if (bit_q == '0) begin
                     state_d = StAccum;
                     j_d     = '0;
                  end else begin
                     bit_d = bit_q - 1'b1;
                  end
               end
            end
         end
         StAccum: begin
            acc_d = mul_out;
            j_d   = j_q + 1'b1;
            if (j_q == LastJ) begin
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StScan;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         j_q      <= '0;
         alpha_q  <= '0;
         e_q      <= '0;
         acc_q    <= '0;
         bit_q    <= '0;
         mul_ph_q <= 1'b0;
         load_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         j_q      <= j_d;
         alpha_q  <= alpha_d;
         e_q      <= e_d;
         acc_q    <= acc_d;
         bit_q    <= bit_d;
         mul_ph_q <= mul_ph_d;
         load_q   <= load_d;
         dout_q   <= dout_d;
      end
   end
endmodule

// File: tb/tb_doubled_syndrome_core.sv
// Self-checking bench for doubled_syndrome_core: directed corner cases plus randomised
// runs compared against a direct evaluation of the syndrome formula.
module tb_doubled_syndrome_core;
   localparam int unsigned M    = 12;
   localparam int unsigned T    = 64;
   localparam int unsigned MW   = 32;
   localparam int unsigned NS   = 2 * T;
   localparam int unsigned FS   = 1 << M;
   localparam logic [M:0]  POLY = 13'h1009;
   localparam int          RunLimit = 20000;

   logic clk, rst;
   int   errors = 0;
   int   checks = 0;

   logic [M-1:0]   p_mem [FS];
   logic [M-1:0]   g_mem [FS];
   logic [M*T-1:0] cipher_v;
   logic [M-1:0]   exp_s [NS];
   logic [M-1:0]   got_s [NS];
   logic [M-1:0]   first_s [NS];

   doubled_syndrome_core_if #(.M(M), .T(T), .MemWidth(MW)) bus ();

   doubled_syndrome_core #(
      .M(M), .T(T), .N(3488), .MemWidth(MW), .Poly(POLY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2*M*MW-1:0] eva_word(input int addr);
      logic [2*M*MW-1:0] w;
      w = '0;
      for (int k = 0; k < 2 * MW; k++) w[M*k +: M] = g_mem[addr * 2 * MW + k];
      return w;
   endfunction

   always @(posedge clk) begin
      if (bus.P_rd_en)   bus.P_dout   <= p_mem[bus.P_rd_addr];
      if (bus.eva_rd_en) bus.eva_dout <= eva_word(int'(bus.eva_rd_addr));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Schoolbook polynomial product followed by long division by the field polynomial.
   function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [2*M-2:0] p;
      p = '0;
      for (int i = 0; i < M; i++)
         if (b[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
      for (int d = 2 * M - 2; d >= M; d--)
         if (p[d]) p = p ^ ({{(M-2){1'b0}}, POLY} << (d - M));
      return p[M-1:0];
   endfunction

   function automatic logic [M-1:0] ref_inv(input logic [M-1:0] x);
      for (int y = 1; y < FS; y++)
         if (ref_mul(x, M'(y)) == M'(1)) return M'(y);
      return '0;
   endfunction

   task automatic build_model();
      logic [M-1:0] a, e, pw;
      for (int j = 0; j < NS; j++) exp_s[j] = '0;
      for (int i = 0; i < M * T; i++) begin
         if (cipher_v[i]) begin
            a = p_mem[i];
            e = g_mem[a];
            if (e != '0) begin
               pw = ref_inv(ref_mul(e, e));
               for (int j = 0; j < NS; j++) begin
                  exp_s[j] = exp_s[j] ^ pw;
                  pw = ref_mul(pw, a);
               end
            end
         end
      end
   endtask

   task automatic run_core(input bit mid_start, output int cyc);
      bus.cipher = cipher_v;
      @(negedge clk);
      bus.operation = 2'b01;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < RunLimit) begin
         @(negedge clk);
         cyc++;
         if (mid_start) bus.start = (cyc == 300);
      end
      bus.start = 1'b0;
      check("run_done", 32'(bus.done), 32'd1);
      @(negedge clk);
   endtask

   task automatic read_synd(input int j, output logic [M-1:0] v);
      bus.synd_rd_en_in   = 1'b1;
      bus.synd_rd_addr_in = 7'(j);
      @(posedge clk);
      #1 v = bus.synd_A_dout_out;
      @(negedge clk);
      bus.synd_rd_en_in = 1'b0;
   endtask

   task automatic read_all();
      for (int j = 0; j < NS; j++) read_synd(j, got_s[j]);
   endtask

   task automatic check_model(input string tag);
      build_model();
      read_all();
      for (int j = 0; j < NS; j++) check($sformatf("%s_S%0d", tag, j), 32'(got_s[j]), 32'(exp_s[j]));
   endtask

   task automatic rand_setup(input int nbits);
      for (int a = 0; a < FS; a++) begin
         p_mem[a] = M'($urandom_range(0, FS - 1));
         g_mem[a] = ($urandom_range(0, 15) == 0) ? '0 : M'($urandom_range(1, FS - 1));
      end
      cipher_v = '0;
      for (int n = 0; n < nbits; n++) cipher_v[$urandom_range(0, M * T - 1)] = 1'b1;
   endtask

   initial begin
      int  cyc;
      bit  seen;
      logic [M-1:0] v;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.operation = 2'b00;
      bus.synd_rd_en_in = 1'b0;
      bus.synd_rd_addr_in = '0;
      bus.cipher = '0;
      repeat (3) @(negedge clk);
      check("rst_done", 32'(bus.done), 0);
      check("rst_p_en", 32'(bus.P_rd_en), 0);
      check("rst_eva_en", 32'(bus.eva_rd_en), 0);
      check("rst_p_addr", 32'(bus.P_rd_addr), 0);
      check("rst_eva_addr", 32'(bus.eva_rd_addr), 0);
      check("rst_dout", 32'(bus.synd_A_dout_out), 0);
      rst = 1'b0;

      // All-zero cipher: pure clear + scan latency, empty syndrome.
      rand_setup(0);
      run_core(1'b0, cyc);
      check("zero_latency", 32'((cyc >= int'(NS + M * T)) && (cyc <= int'(NS + M * T + 1))), 1);
      check_model("zero");

      // g = 1, P[i] = i.
      for (int a = 0; a < FS; a++) begin
         g_mem[a] = M'(1);
         p_mem[a] = M'(a);
      end
      cipher_v = '0;
      cipher_v[2] = 1'b1;
      run_core(1'b0, cyc);
      read_all();
      check("pow2_S0", 32'(got_s[0]), 32'h001);
      check("pow2_S1", 32'(got_s[1]), 32'h002);
      check("pow2_S2", 32'(got_s[2]), 32'h004);
      check("pow2_S12", 32'(got_s[12]), 32'h009);
      cipher_v = '0;
      cipher_v[3] = 1'b1;
      run_core(1'b0, cyc);
      check_model("pow3");

      // alpha = 0: only S_0 moves.
      cipher_v = '0;
      cipher_v[0] = 1'b1;
      run_core(1'b0, cyc);
      read_all();
      for (int j = 0; j < NS; j++) check($sformatf("alpha0_S%0d", j), 32'(got_s[j]), (j == 0) ? 1 : 0);

      // Lane select: lane k of every word holds k+1, alpha = 7 -> e = 8.
      for (int a = 0; a < FS; a++) g_mem[a] = M'((a % (2 * MW)) + 1);
      p_mem[5] = M'(7);
      cipher_v = '0;
      cipher_v[5] = 1'b1;
      run_core(1'b0, cyc);
      check_model("lane");
      check("lane_inv", 32'(ref_mul(ref_mul(got_s[0], M'(8)), M'(8))), 1);
      check("lane_s1", 32'(got_s[1]), 32'(ref_mul(got_s[0], M'(7))));

      for (int r = 0; r < 3; r++) begin
         rand_setup(4);
         run_core(1'b0, cyc);
         check_model($sformatf("rand%0d", r));
      end

      // Same inputs again, with a stray start mid-run.
      for (int j = 0; j < NS; j++) first_s[j] = got_s[j];
      run_core(1'b1, cyc);
      read_all();
      for (int j = 0; j < NS; j++) check($sformatf("rerun_S%0d", j), 32'(got_s[j]), 32'(first_s[j]));

      // Unsupported operation must not start a run.
      @(negedge clk);
      bus.operation = 2'b10;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("bad_op_done", 32'(seen), 0);
      read_synd(1, v);
      check("bad_op_idle_read", 32'(v), 32'(exp_s[1]));

      // Reset in the middle of accumulation.
      rand_setup(3);
      cipher_v[10] = 1'b1;
      bus.cipher = cipher_v;
      @(negedge clk);
      bus.operation = 2'b01;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.eva_rd_en && cyc < RunLimit) begin
         @(negedge clk);
         cyc++;
      end
      check("eva_seen", 32'(bus.eva_rd_en), 1);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_done", 32'(bus.done), 0);
      check("mid_rst_p_en", 32'(bus.P_rd_en), 0);
      check("mid_rst_eva_en", 32'(bus.eva_rd_en), 0);
      check("mid_rst_p_addr", 32'(bus.P_rd_addr), 0);
      check("mid_rst_dout", 32'(bus.synd_A_dout_out), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("mid_rst_no_done", 32'(seen), 0);
      run_core(1'b0, cyc);
      check_model("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
